// File: rtl/rr_channel_mux_pkg.sv
// rr_channel_mux_pkg: mode encoding and the round-robin pick helper.
package rr_channel_mux_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_ROUND_ROBIN = 1'b1} mode_e;
  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;
  // First requester at or after ptr (mod ch); supports up to 64 channels.
  function automatic pick_t rr_pick(input logic [63:0] req, input int ptr, input int ch);
    pick_t p;
    p = '0;
    for (int k = ch - 1; k >= 0; k--) begin
      int j;
      j = (ptr + k) % ch;
      if (req[j]) begin
        p.found = 1'b1;
        p.idx = 6'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_channel_mux_if.sv
// rr_channel_mux_if: per-channel producer side plus single consumer side of the mux.
interface rr_channel_mux_if #(
  parameter int CH = 8,
  parameter int W  = 8
);
  localparam int SELW = $clog2(CH);
  logic            mode;
  logic [SELW-1:0] sel_in;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;
  logic            out_valid;
  logic            out_ready;
  modport master (
    output mode, sel_in, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input  mode, sel_in, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_channel_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr.
module rr_arbiter
  import rr_channel_mux_pkg::*;
#(
  parameter int CH = 8,
  localparam int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [CH-1:0]   gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_found
);
  pick_t p;
  always_comb begin
    p = rr_pick(64'(req), int'(ptr), CH);
    gnt_found = p.found;
    gnt_idx = SELW'(p.idx);
    gnt_onehot = p.found ? CH'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/rr_channel_mux.sv
// rr_channel_mux: CH:1 registered channel mux with manual or round-robin selection.
module rr_channel_mux
  import rr_channel_mux_pkg::*;
#(
  parameter int CH = 8,
  parameter int W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_channel_mux_if.slave bus
);
  localparam int SELW = $clog2(CH);
  logic [SELW-1:0] ptr;
  logic [CH-1:0]   rr_oh;
  logic [SELW-1:0] rr_idx;
  logic            rr_found;
  logic            rr;
  logic            load_en;
  logic            g_any;
  logic [SELW-1:0] g_idx;
  logic [W-1:0]    g_data;
  rr_arbiter #(.CH(CH)) u_arb (
    .req(bus.in_valid),
    .ptr(ptr),
    .gnt_onehot(rr_oh),
    .gnt_idx(rr_idx),
    .gnt_found(rr_found)
  );
  // in_ready is held low during reset even though the cleared output register would allow a load.
  always_comb begin
    rr = bus.mode == MODE_ROUND_ROBIN;
    load_en = !bus.out_valid || bus.out_ready;
    g_idx = rr ? rr_idx : bus.sel_in;
    g_any = rst_n && load_en && (rr ? rr_found : bus.in_valid[bus.sel_in]);
    g_data = bus.in_data[g_idx*W +: W];
    bus.in_ready = !g_any ? '0 : rr ? rr_oh : CH'(1) << bus.sel_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
    end else if (g_any) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= g_data;
      bus.out_ch <= g_idx;
      if (rr) ptr <= g_idx + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
